// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the run/halt/step clock-enable controller.
//   state_t   : controller state (running, halted, single-stepping)
//   clamp_div : maps a requested divisor of 0 onto the legal minimum of 1
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    StRunning  = 2'd0,
    StHalted   = 2'd1,
    StStepping = 2'd2
  } state_t;

  localparam int unsigned DefCntW     = 8;
  localparam int unsigned DefDivRst   = 4;
  localparam bit          DefRunOnRst = 1'b1;

  function automatic int unsigned clamp_div(input int unsigned div);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/clk_en_ctr.sv
// Divide counter for the clock-enable controller.
//   CLK : system clock
//   RST : asynchronous active-high reset
//   clr : hold the counter at 0 (takes priority over en)
//   en  : advance the counter, wrapping to 0 after div-1
//   div : current divisor, always >= 1
//   tc  : terminal count, high while the counter equals div-1
module clk_en_ctr #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             tc
);

  logic [CNT_W-1:0] ctr_q, ctr_d;

  // div >= 1 always, so div-1 never underflows
  assign tc = (ctr_q == div - CNT_W'(1));

  always_comb begin
    ctr_d = ctr_q;
    if (clr) begin
      ctr_d = '0;
    end else if (en) begin
      ctr_d = tc ? '0 : ctr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/clk_ctrl.sv
// Run/halt/step clock-enable controller. Issues a one-cycle CLK_EN every DIV_CUR
// system clocks; supports debug halt, single-step and runtime divisor changes that
// only take effect on a period boundary (or right away while halted).
//   CLK      : system clock
//   RST      : asynchronous active-high reset
//   DIV_REQ  : one-cycle request to load DIV_VAL (0 is treated as 1)
//   DIV_VAL  : requested divisor
//   DIV_ACK  : one-cycle pulse in the cycle the new divisor is in use
//   DIV_CUR  : divisor currently in use
//   HALT_REQ : level, stop issuing CLK_EN at the next period boundary
//   STEP     : one-cycle pulse, run exactly one period while halted
//   CLK_EN   : clock-enable pulse, driven from flops only
//   HALTED   : high while halted
module clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned DIV_RST    = DefDivRst,
  parameter bit          RUN_ON_RST = DefRunOnRst
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIV_REQ,
  input  logic [CNT_W-1:0] DIV_VAL,
  output logic             DIV_ACK,
  output logic [CNT_W-1:0] DIV_CUR,
  input  logic             HALT_REQ,
  input  logic             STEP,
  output logic             CLK_EN,
  output logic             HALTED
);

  localparam state_t StReset = RUN_ON_RST ? StRunning : StHalted;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_ack_q, div_ack_d;

  logic             tc;
  logic             halted_st;
  logic             run_st;
  logic             boundary;
  logic [CNT_W-1:0] div_val_cl;

  assign halted_st  = (st_q == StHalted);
  assign run_st     = !halted_st;
  assign boundary   = run_st && tc;
  assign div_val_cl = CNT_W'(clamp_div(32'(DIV_VAL)));

  clk_en_ctr #(
    .CNT_W(CNT_W)
  ) u_ctr (
    .CLK(CLK),
    .RST(RST),
    .clr(halted_st),
    .en (run_st),
    .div(div_cur_q),
    .tc (tc)
  );

  // State transitions
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StRunning: begin
        if (boundary && HALT_REQ) st_d = StHalted;
      end
      StHalted: begin
        if (!HALT_REQ) begin
          st_d = StRunning;
        end else if (STEP) begin
          st_d = StStepping;
        end
      end
      StStepping: begin
        if (boundary) st_d = HALT_REQ ? StHalted : StRunning;
      end
      default: st_d = StHalted;
    endcase
  end

  // Divisor update. While halted the counter sits at 0, so a request can be applied
  // straight away; otherwise it waits for the terminal count so no period is cut short.
  always_comb begin
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    div_ack_d  = 1'b0;
    if (halted_st && DIV_REQ) begin
      // Newest request wins over anything still pending
      div_cur_d  = div_val_cl;
      pend_vld_d = 1'b0;
      div_ack_d  = 1'b1;
    end else begin
      if (pend_vld_q && (boundary || halted_st)) begin
        div_cur_d  = div_pend_q;
        pend_vld_d = 1'b0;
        div_ack_d  = 1'b1;
      end
      // A request in the apply cycle is kept for the following boundary
      if (DIV_REQ) begin
        div_pend_d = div_val_cl;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q       <= StReset;
      div_cur_q  <= CNT_W'(DIV_RST);
      div_pend_q <= '0;
      pend_vld_q <= 1'b0;
      div_ack_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      div_ack_q  <= div_ack_d;
    end
  end

  assign CLK_EN  = boundary;
  assign HALTED  = halted_st;
  assign DIV_CUR = div_cur_q;
  assign DIV_ACK = div_ack_q;

endmodule

// File: doc/clk_ctrl.md
Name: clk_ctrl

Overview:
Run/halt/step clock controller for the LittleRISC-V core. It generates a single-cycle clock-enable pulse (CLK_EN) every DIV_CUR cycles of the system clock, so downstream logic stays on one clock domain with no generated clocks. It also supports runtime reprogramming of the divide ratio, a debug halt and single-step. The divisor is only switched on a period boundary, so no period is ever truncated.

Parameters:
CNT_W, 8, width of the divide counter and divisor; legal divisor range 1..2^CNT_W-1.
DIV_RST, 4, divisor loaded at reset; must be 1..2^CNT_W-1.
RUN_ON_RST, 1, 1 = RUNNING after reset, 0 = HALTED after reset.

Ports:
CLK  input  1  system clock, all logic on posedge.
RST  input  1  asynchronous, active-high reset.
DIV_REQ  input  1  single-cycle request to load DIV_VAL as the new divisor.
DIV_VAL  input  CNT_W  requested divisor; 0 is clamped to 1.
DIV_ACK  output  1  one-cycle pulse in the cycle the new divisor takes effect.
DIV_CUR  output  CNT_W  divisor currently in use.
HALT_REQ  input  1  level; 1 = stop issuing CLK_EN at the next period boundary.
STEP  input  1  single-cycle pulse; issue exactly one period while halted.
CLK_EN  output  1  one-cycle enable pulse, once per DIV_CUR cycles.
HALTED  output  1  1 while in HALTED state.

Behaviour:
- Reset (async assert, sync release):
  - state = RUNNING if RUN_ON_RST else HALTED; ctr = 0; div_cur = DIV_RST; pend_vld = 0.
  - CLK_EN = 0, DIV_ACK = 0, HALTED = !RUN_ON_RST.
- States: RUNNING, HALTED, STEPPING (enum in package).
- Counter:
  - In RUNNING or STEPPING, ctr increments each cycle and wraps to 0 after div_cur-1.
  - In HALTED, ctr is held at 0.
- tc = (ctr == div_cur-1).
- CLK_EN = tc && state != HALTED, decoded from flops only; there is no combinational path from any input to CLK_EN.
- First CLK_EN after entering RUNNING or STEPPING with ctr = 0 occurs div_cur cycles later (cycle index div_cur-1).
- div_cur = 1 -> CLK_EN high every cycle while running.
- Transitions:
  - RUNNING -> HALTED: on a tc cycle with HALT_REQ = 1. The CLK_EN of that cycle is still issued.
  - HALTED -> RUNNING: HALT_REQ = 0, ctr = 0.
  - HALTED -> STEPPING: HALT_REQ = 1 and STEP = 1.
  - STEPPING -> HALTED: on tc if HALT_REQ = 1; otherwise STEPPING -> RUNNING on tc.
  - STEP is ignored outside HALTED. STEP while HALT_REQ = 0 is irrelevant because the block leaves HALTED.
- Divisor change:
  - DIV_REQ latches clamp(DIV_VAL) into div_pend and sets pend_vld.
  - A DIV_REQ while pend_vld = 1 overwrites div_pend (last request wins); only one DIV_ACK is issued.
- Apply point:
  - Running or stepping: the tc cycle. Next cycle div_cur = div_pend and ctr = 0.
  - Halted: the cycle after latching.
  - DIV_ACK pulses in the cycle div_cur updates; pend_vld clears in the same cycle.
- Simultaneous apply and DIV_REQ: the old div_pend is applied and DIV_ACK fires. The new value is latched with pend_vld kept at 1, and is applied at the following boundary.
- Apply coincident with RUNNING->HALTED: both happen. Next cycle the block is HALTED with the new div_cur.
- Reset mid-period or mid-step: abort immediately to the reset state; any pending divisor is discarded.
- Width: DIV_VAL is CNT_W bits; no wider arithmetic. The div_cur-1 compare never underflows because div_cur >= 1.

Decomposition:
- Package clk_ctrl_pkg:
  - state_t enum {RUNNING, HALTED, STEPPING};
  - function clamp_div(0 -> 1);
  - localparam defaults.
- Sub-module clk_en_ctr: counter with clear, enable, divisor input and tc output. clk_ctrl holds the FSM and the pending-divisor register.

Test Plan:
- Reset with DIV_RST = 4, RUN_ON_RST = 1, release at t0 -> CLK_EN at cycles 3, 7, 11; DIV_CUR = 4; HALTED = 0.
- DIV_REQ with DIV_VAL = 2 at cycle 5 (ctr = 1 of div 4) -> DIV_ACK at cycle 8 and DIV_CUR = 2 from cycle 8. CLK_EN at 7, then at 9, 11, 13.
- HALT_REQ = 1 at cycle 1 -> CLK_EN at cycle 3, HALTED = 1 from cycle 4, no further CLK_EN. STEP pulse at cycle 10 -> exactly one CLK_EN at cycle 14, HALTED again from cycle 15.
- While halted: DIV_REQ with DIV_VAL = 0 -> DIV_ACK next cycle, DIV_CUR = 1. Then release HALT_REQ -> CLK_EN every cycle.
- Back-to-back DIV_REQ with 6 then 3 within one period -> single DIV_ACK at the boundary, DIV_CUR = 3. DIV_REQ on the tc cycle -> DIV_ACK at that boundary and a second DIV_ACK at the next boundary.
- Assert RST mid-STEPPING (ctr = 2) -> outputs return to reset values asynchronously, pend_vld cleared, and no CLK_EN is seen during reset.
